// File: rtl/pipelined_addsub_if.sv
// Valid/ready operand and result bundle for pipelined_addsub.
// The master side drives operands and accepts results; the slave side is the adder.
interface pipelined_addsub_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;
  logic             zero;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, sum, carry_out, overflow, zero
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, sum, carry_out, overflow, zero
  );
endinterface

// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement adder/subtractor: WIDTH-bit carry chain split into STAGES registered segments.
// Define ADDSUB_SAT_EN to clamp the result to the signed range on overflow; otherwise the sum wraps.
module pipelined_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic              clk,
  input  logic              rst,
  pipelined_addsub_if.slave io
);
  localparam int SEG = WIDTH / STAGES;

  logic             en;
  logic             outValid_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             overflow_q;
  logic             zero_q;

  // The whole pipeline advances as one; a held result freezes every stage.
  assign en           = !outValid_q || io.out_ready;
  assign io.in_ready  = en;
  assign io.out_valid = outValid_q;
  assign io.sum       = sum_q;
  assign io.carry_out = carry_q;
  assign io.overflow  = overflow_q;
  assign io.zero      = zero_q;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * SEG;
    localparam int UP = WIDTH - LO;

    logic [UP-1:0]     aIn;
    logic [UP-1:0]     bIn;
    logic              cIn;
    logic              vIn;
    logic [LO+SEG-1:0] sumNext;
    logic [SEG:0]      segSum;

    if (k == 0) begin : g_src
      assign aIn     = io.a;
      assign bIn     = io.sub ? ~io.b : io.b;
      assign cIn     = io.sub;
      assign vIn     = io.in_valid;
      assign sumNext = segSum[SEG-1:0];
    end else begin : g_src
      assign aIn     = g_stage[k-1].g_reg.aSkew_q;
      assign bIn     = g_stage[k-1].g_reg.bSkew_q;
      assign cIn     = g_stage[k-1].g_reg.cry_q;
      assign vIn     = g_stage[k-1].g_reg.valid_q;
      assign sumNext = {segSum[SEG-1:0], g_stage[k-1].g_reg.psum_q};
    end

    assign segSum = {1'b0, aIn[SEG-1:0]} + {1'b0, bIn[SEG-1:0]} + {{SEG{1'b0}}, cIn};

    if (k < STAGES - 1) begin : g_reg
      logic              valid_q;
      logic              cry_q;
      logic [UP-SEG-1:0] aSkew_q;
      logic [UP-SEG-1:0] bSkew_q;
      logic [LO+SEG-1:0] psum_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          valid_q <= 1'b0;
        end else if (en) begin
          valid_q <= vIn;
          cry_q   <= segSum[SEG];
          aSkew_q <= aIn[UP-1:SEG];
          bSkew_q <= bIn[UP-1:SEG];
          psum_q  <= sumNext;
        end
      end
    end else begin : g_out
      logic [WIDTH-1:0] res_d;
      logic             carry_d;
      logic             overflow_d;

      // Overflow is carry into the MSB (recovered from the MSB sum bit) xor carry out of it.
      always_comb begin
        carry_d    = segSum[SEG];
        overflow_d = (aIn[SEG-1] ^ bIn[SEG-1] ^ segSum[SEG-1]) ^ segSum[SEG];
        res_d      = sumNext;
`ifdef ADDSUB_SAT_EN
        if (overflow_d)
          res_d = aIn[SEG-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          outValid_q <= 1'b0;
          sum_q      <= '0;
          carry_q    <= 1'b0;
          overflow_q <= 1'b0;
          zero_q     <= 1'b0;
        end else if (en) begin
          outValid_q <= vIn;
          sum_q      <= res_d;
          carry_q    <= carry_d;
          overflow_q <= overflow_d;
          zero_q     <= (res_d == '0);
        end
      end
    end
  end
endmodule

// File: tb/tb_pipelined_addsub.sv
// Self-checking bench for pipelined_addsub: table vectors, stall/flush sequences and
// randomized traffic against a slot-array reference model, plus a STAGES=1 instance.
module tb_pipelined_addsub;
  localparam int W = 32;
  localparam int S = 4;

  typedef struct {
    logic [W-1:0] sum;
    logic         carry;
    logic         ovf;
    logic         zero;
  } res_t;

  typedef struct {
    logic v;
    res_t r;
  } slot_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] sum;
    logic         carry;
    logic         ovf;
    logic         zero;
  } vec_t;

  logic  clk = 1'b0;
  logic  rst;
  int    nCompared = 0;
  int    nMismatch = 0;
  slot_t model[S];
  logic  obsValid;
  logic  obsReady;
  res_t  obs;
  vec_t  vecs[8];

  pipelined_addsub_if #(.WIDTH(W)) ifc ();
  pipelined_addsub_if #(.WIDTH(W)) ifc1 ();

  pipelined_addsub #(.WIDTH(W), .STAGES(S)) u_dut (.clk(clk), .rst(rst), .io(ifc));
  pipelined_addsub #(.WIDTH(W), .STAGES(1)) u_dut1 (.clk(clk), .rst(rst), .io(ifc1));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference result from plain signed/unsigned arithmetic.
  function automatic res_t refModel(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    res_t   r;
    longint sa, sb, ua, ub, st;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    st = sub ? sa - sb : sa + sb;
    r.carry = sub ? (ua >= ub) : ((ua + ub) > 64'h0000_0000_FFFF_FFFF);
    r.ovf   = (st > 64'sd2147483647) || (st < -64'sd2147483648);
    r.sum   = st[W-1:0];
`ifdef ADDSUB_SAT_EN
    if (r.ovf) r.sum = (st > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
    r.zero = (r.sum == '0);
    return r;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One clock: check against the model mid-cycle, then advance the model at the edge.
  task automatic cycle();
    logic expEn;
    @(negedge clk);
    expEn = !model[S-1].v || ifc.out_ready;
    chk("in_ready", ifc.in_ready, expEn);
    chk("out_valid", ifc.out_valid, model[S-1].v);
    obsValid = ifc.out_valid;
    obsReady = ifc.in_ready;
    obs = '{ifc.sum, ifc.carry_out, ifc.overflow, ifc.zero};
    if (model[S-1].v) begin
      chk("model_sum", ifc.sum, model[S-1].r.sum);
      chk("model_carry", ifc.carry_out, model[S-1].r.carry);
      chk("model_overflow", ifc.overflow, model[S-1].r.ovf);
      chk("model_zero", ifc.zero, model[S-1].r.zero);
    end
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < S; i++) model[i].v = 1'b0;
    end else if (expEn) begin
      for (int i = S - 1; i > 0; i--) model[i] = model[i-1];
      model[0].v = ifc.in_valid;
      model[0].r = refModel(ifc.a, ifc.b, ifc.sub);
    end
    #1;
  endtask

  task automatic drain();
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b1;
    repeat (S + 2) cycle();
  endtask

  task automatic checkOutput(input vec_t v, input int lat, input int idx);
    chk($sformatf("vec%0d_latency", idx), lat, S);
    chk($sformatf("vec%0d_sum", idx), obs.sum, v.sum);
    chk($sformatf("vec%0d_carry", idx), obs.carry, v.carry);
    chk($sformatf("vec%0d_overflow", idx), obs.ovf, v.ovf);
    chk($sformatf("vec%0d_zero", idx), obs.zero, v.zero);
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    int   lat;
    logic seen;
    ifc.a         = v.a;
    ifc.b         = v.b;
    ifc.sub       = v.sub;
    ifc.in_valid  = 1'b1;
    ifc.out_ready = 1'b1;
    cycle();
    ifc.in_valid = 1'b0;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 4 * S) begin
      cycle();
      lat++;
      if (obsValid) seen = 1'b1;
    end
    if (!seen) chk($sformatf("vec%0d_timeout", idx), 0, 1);
    else checkOutput(v, lat, idx);
  endtask

  initial begin
    logic [W-1:0] pool[6];
    logic [3:0]   readyPat;
    int           sent, recv, ghosts;

    vecs[0] = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0};
`ifdef ADDSUB_SAT_EN
    vecs[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h8000_0000, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000, 1'b1, 1'b1, 1'b0};
`else
    vecs[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
`endif
    vecs[2] = '{32'h0000_0005, 32'h0000_0005, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{32'h0000_0003, 32'h0000_0005, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};

    pool = '{32'h0, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_FFFF, 32'h1};
    readyPat = 4'b1001;

    rst = 1'b1;
    ifc.in_valid = 1'b0; ifc.out_ready = 1'b1; ifc.a = '0; ifc.b = '0; ifc.sub = 1'b0;
    ifc1.in_valid = 1'b0; ifc1.out_ready = 1'b1; ifc1.a = '0; ifc1.b = '0; ifc1.sub = 1'b0;
    for (int i = 0; i < S; i++) model[i] = '{1'b0, '{'0, 1'b0, 1'b0, 1'b0}};

    cycle();
    cycle();
    chk("rst_out_valid", ifc.out_valid, 0);
    chk("rst_sum", ifc.sum, 0);
    chk("rst_carry", ifc.carry_out, 0);
    chk("rst_overflow", ifc.overflow, 0);
    chk("rst_zero", ifc.zero, 0);
    chk("rst_in_ready", ifc.in_ready, 1);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) applyStimulus(vecs[i], i);
    drain();

    // Eight back-to-back ops under an out_ready pattern 1,0,0,1,...
    sent = 0;
    recv = 0;
    for (int c = 0; c < 80 && recv < 8; c++) begin
      ifc.out_ready = readyPat[c % 4];
      ifc.in_valid  = (sent < 8);
      ifc.a         = 32'h1000_0000 * sent + 32'h0000_FFF0 + sent;
      ifc.b         = 32'h0000_0011 * (sent + 1);
      ifc.sub       = sent[0];
      cycle();
      if (ifc.in_valid && obsReady) sent++;
      if (obsValid && ifc.out_ready) recv++;
    end
    chk("b2b_sent", sent, 8);
    chk("b2b_received", recv, 8);
    drain();

    // Randomized traffic with random backpressure.
    for (int c = 0; c < 400; c++) begin
      ifc.in_valid  = ($urandom_range(0, 3) != 0);
      ifc.out_ready = ($urandom_range(0, 3) != 0);
      ifc.a   = ($urandom_range(0, 2) == 0) ? pool[$urandom_range(0, 5)] : $urandom;
      ifc.b   = ($urandom_range(0, 2) == 0) ? pool[$urandom_range(0, 5)] : $urandom;
      ifc.sub = $urandom_range(0, 1);
      cycle();
    end
    drain();

    // Reset with three ops in flight: none of them may ever emerge.
    ifc.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ifc.in_valid = 1'b1;
      ifc.a = 32'h0000_0100 + i;
      ifc.b = 32'h0000_0001;
      ifc.sub = 1'b0;
      cycle();
    end
    ifc.in_valid = 1'b0;
    rst = 1'b1;
    cycle();
    chk("flush_out_valid", ifc.out_valid, 0);
    rst = 1'b0;
    ghosts = 0;
    repeat (S + 3) begin
      cycle();
      if (obsValid) ghosts++;
    end
    chk("flush_no_results", ghosts, 0);

    // Single-stage instance: registered result one cycle after acceptance.
    chk("s1_in_ready", ifc1.in_ready, 1);
    ifc1.a = 32'h0000_FFFF;
    ifc1.b = 32'h0000_0001;
    ifc1.sub = 1'b0;
    ifc1.in_valid = 1'b1;
    cycle();
    ifc1.in_valid = 1'b0;
    chk("s1_out_valid", ifc1.out_valid, 1);
    chk("s1_sum", ifc1.sum, 32'h0001_0000);
    chk("s1_carry", ifc1.carry_out, 0);
    chk("s1_overflow", ifc1.overflow, 0);
    chk("s1_zero", ifc1.zero, 0);
    cycle();
    chk("s1_out_valid_after", ifc1.out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end
endmodule
